// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/accumulator control path.
//  - command kinds carried on cmd_kind
//  - ALU select codes driven on alu_sel
//  - sequencer FSM state encoding
//  - default datapath width
package alu_pkg;

   localparam int unsigned ALU_DW  = 8;
   localparam int unsigned KIND_W  = 2;
   localparam int unsigned SEL_W   = 4;
   localparam int unsigned STATE_W = 3;

   // Command kinds
   localparam logic [KIND_W-1:0] KIND_EXEC  = 2'b00;
   localparam logic [KIND_W-1:0] KIND_LOAD  = 2'b01;
   localparam logic [KIND_W-1:0] KIND_CLEAR = 2'b10;
   localparam logic [KIND_W-1:0] KIND_READ  = 2'b11;

   // ALU select codes (operand A = immediate, operand B = accumulator)
   localparam logic [SEL_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [SEL_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [SEL_W-1:0] ALU_AND   = 4'd2;
   localparam logic [SEL_W-1:0] ALU_OR    = 4'd3;
   localparam logic [SEL_W-1:0] ALU_XOR   = 4'd4;
   localparam logic [SEL_W-1:0] ALU_NOT   = 4'd5;
   localparam logic [SEL_W-1:0] ALU_SHL   = 4'd6;
   localparam logic [SEL_W-1:0] ALU_SHR   = 4'd7;
   localparam logic [SEL_W-1:0] ALU_INC   = 4'd8;
   localparam logic [SEL_W-1:0] ALU_DEC   = 4'd9;
   localparam logic [SEL_W-1:0] ALU_PASSA = 4'd10;
   localparam logic [SEL_W-1:0] ALU_PASSB = 4'd11;
   localparam logic [SEL_W-1:0] ALU_NAND  = 4'd12;
   localparam logic [SEL_W-1:0] ALU_NOR   = 4'd13;
   localparam logic [SEL_W-1:0] ALU_XNOR  = 4'd14;
   localparam logic [SEL_W-1:0] ALU_EQ    = 4'd15;

   // Sequencer FSM states
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
   localparam logic [STATE_W-1:0] ST_OPND  = 3'd2;
   localparam logic [STATE_W-1:0] ST_EXEC  = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   // LOAD and CLEAR both start by pulsing the accumulator clear
   function automatic logic kind_clears_acc(input logic [KIND_W-1:0] kind);
      return (kind == KIND_LOAD) || (kind == KIND_CLEAR);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO for the ALU op sequencer.
//  clk, rst     clock, synchronous active-high reset (empties the FIFO)
//  push, wdata  write one entry (ignored when full)
//  pop          drop the head entry (ignored when empty)
//  rdata_c      head entry, combinational from storage
//  empty_c      FIFO currently empty
//  empty_d_c    FIFO will be empty after this edge
//  ready        registered "not full", 0 while in reset
// DEPTH must be a power of two so pointers wrap naturally.
module cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata_c,
   output logic             empty_c,
   output logic             empty_d_c,
   output logic             ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_d;
   logic             push_ok;
   logic             pop_ok;

   // Qualified handshakes and next occupancy
   always_comb begin
      push_ok   = push && (count != CW'(DEPTH));
      pop_ok    = pop && (count != CW'(0));
      count_d   = count + CW'(push_ok) - CW'(pop_ok);
      rdata_c   = mem[rd_ptr];
      empty_c   = (count == CW'(0));
      empty_d_c = (count_d == CW'(0));
   end

   // Pointers, occupancy and registered not-full
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_d;
         ready <= (count_d != CW'(DEPTH));
      end
   end

   // Storage needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: queues op commands and sequences the operand tri-buffer,
// ALU select and accumulator controls for each, then presents the captured
// ALU result on a valid/ready port.
//  clk, rst                  clock, synchronous active-high reset
//  cmd_valid/cmd_ready       command handshake (cmd_ready = FIFO not full)
//  cmd_kind/cmd_sel/cmd_imm  EXEC/LOAD/CLEAR/READ, ALU select, operand A
//  opnd_en/opnd_data         operand tri-buffer enable and data (ALU A)
//  alu_sel                   ALU select
//  alu_out/alu_carry         ALU combinational result and carry
//  acc_en/acc_rst            accumulator load / clear
//  res_valid/res_ready       result handshake
//  res_data/res_carry        captured result and carry
//  busy                      command in flight or queued
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = ALU_DW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [KIND_W-1:0] cmd_kind,
   input  logic [SEL_W-1:0]  cmd_sel,
   input  logic [DW-1:0]     cmd_imm,
   output logic              opnd_en,
   output logic [DW-1:0]     opnd_data,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DW-1:0]     alu_out,
   input  logic              alu_carry,
   output logic              acc_en,
   output logic              acc_rst,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DW-1:0]     res_data,
   output logic              res_carry,
   output logic              busy
);

   localparam int unsigned CMD_W = KIND_W + SEL_W + DW;

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_d;

   logic [CMD_W-1:0]   head_c;
   logic [KIND_W-1:0]  head_kind_c;
   logic [SEL_W-1:0]   head_sel_c;
   logic [DW-1:0]      head_imm_c;
   logic               fifo_empty_c;
   logic               fifo_empty_d_c;
   logic               fifo_push_c;
   logic               pop_c;

   // Latched command being sequenced
   logic [KIND_W-1:0]  cmd_kind_q;
   logic [SEL_W-1:0]   cmd_sel_q;
   logic [DW-1:0]      cmd_imm_q;

   // Command the next state acts on (head if popping this cycle)
   logic [KIND_W-1:0]  nxt_kind_c;
   logic [SEL_W-1:0]   nxt_sel_c;
   logic [DW-1:0]      nxt_imm_c;

   // Next values of the registered outputs
   logic               opnd_en_d;
   logic [DW-1:0]      opnd_data_d;
   logic [SEL_W-1:0]   alu_sel_d;
   logic               acc_en_d;
   logic               acc_rst_d;
   logic               res_valid_d;
   logic               busy_d;

   assign fifo_push_c = cmd_valid && cmd_ready;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push_c),
      .wdata     ({cmd_kind, cmd_sel, cmd_imm}),
      .pop       (pop_c),
      .rdata_c   (head_c),
      .empty_c   (fifo_empty_c),
      .empty_d_c (fifo_empty_d_c),
      .ready     (cmd_ready)
   );

   // Unpack FIFO head
   always_comb begin
      head_kind_c = head_c[CMD_W-1 -: KIND_W];
      head_sel_c  = head_c[DW +: SEL_W];
      head_imm_c  = head_c[DW-1:0];
   end

   // Next state, FIFO pop and next registered outputs
   always_comb begin
      state_d     = state;
      pop_c       = 1'b0;
      nxt_kind_c  = cmd_kind_q;
      nxt_sel_c   = cmd_sel_q;
      nxt_imm_c   = cmd_imm_q;
      opnd_en_d   = 1'b0;
      opnd_data_d = '0;
      alu_sel_d   = ALU_ADD;
      acc_en_d    = 1'b0;
      acc_rst_d   = 1'b0;
      res_valid_d = 1'b0;
      busy_d      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!fifo_empty_c) begin
               pop_c   = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = (cmd_kind_q == KIND_CLEAR) ? ST_DONE : ST_OPND;
         end
         ST_OPND: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_DONE;
         ST_DONE: begin
            // Handing off the result frees the sequencer; fetch the next
            // queued command right away to sustain one command per 4 cycles.
            if (res_valid && res_ready) begin
               if (!fifo_empty_c) begin
                  pop_c   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop_c) begin
         nxt_kind_c = head_kind_c;
         nxt_sel_c  = head_sel_c;
         nxt_imm_c  = head_imm_c;
      end

      // Operand bus is driven only in OPND/EXEC; READ adds zero to the acc
      opnd_en_d = (state_d == ST_OPND) || (state_d == ST_EXEC);
      if (opnd_en_d && (nxt_kind_c != KIND_READ)) opnd_data_d = nxt_imm_c;
      if (opnd_en_d && (nxt_kind_c == KIND_EXEC)) alu_sel_d = nxt_sel_c;

      acc_en_d    = (state_d == ST_EXEC) && (nxt_kind_c != KIND_READ);
      acc_rst_d   = (state_d == ST_FETCH) && kind_clears_acc(nxt_kind_c);
      res_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE) || !fifo_empty_d_c;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   // Registered outputs, command latch and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         opnd_en    <= 1'b0;
         opnd_data  <= '0;
         alu_sel    <= '0;
         acc_en     <= 1'b0;
         acc_rst    <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
         cmd_kind_q <= KIND_EXEC;
         cmd_sel_q  <= '0;
         cmd_imm_q  <= '0;
         res_data   <= '0;
         res_carry  <= 1'b0;
      end else begin
         opnd_en    <= opnd_en_d;
         opnd_data  <= opnd_data_d;
         alu_sel    <= alu_sel_d;
         acc_en     <= acc_en_d;
         acc_rst    <= acc_rst_d;
         res_valid  <= res_valid_d;
         busy       <= busy_d;
         cmd_kind_q <= nxt_kind_c;
         cmd_sel_q  <= nxt_sel_c;
         cmd_imm_q  <= nxt_imm_c;
         // Result is sampled as EXEC ends; CLEAR reports zero without the ALU
         if (state == ST_EXEC) begin
            res_data  <= alu_out;
            res_carry <= alu_carry;
         end else if ((state == ST_FETCH) && (cmd_kind_q == KIND_CLEAR)) begin
            res_data  <= '0;
            res_carry <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with behavioural ALU, accumulator and
// operand tri-buffer models around it.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_kind;
   logic [3:0] cmd_sel;
   logic [7:0] cmd_imm;
   logic       opnd_en;
   logic [7:0] opnd_data;
   logic [3:0] alu_sel;
   logic [7:0] alu_out;
   logic       alu_carry;
   logic       acc_en;
   logic       acc_rst;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic       busy;

   logic [7:0] alu_a;
   logic [7:0] acc;
   logic [8:0] alu_w;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   logic saw_acc_en;

   alu_op_sequencer #(.DEPTH(4), .DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_kind  (cmd_kind),
      .cmd_sel   (cmd_sel),
      .cmd_imm   (cmd_imm),
      .opnd_en   (opnd_en),
      .opnd_data (opnd_data),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .acc_en    (acc_en),
      .acc_rst   (acc_rst),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_carry (res_carry),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tri-buffer: released bus reads as zero
   assign alu_a = opnd_en ? opnd_data : 8'h00;

   // ALU model: A = operand bus, B = accumulator
   always_comb begin
      alu_w = 9'h000;
      case (alu_sel)
         ALU_ADD:   alu_w = {1'b0, alu_a} + {1'b0, acc};
         ALU_SUB:   alu_w = {1'b0, alu_a} - {1'b0, acc};
         ALU_AND:   alu_w = {1'b0, alu_a & acc};
         ALU_OR:    alu_w = {1'b0, alu_a | acc};
         ALU_XOR:   alu_w = {1'b0, alu_a ^ acc};
         ALU_NOT:   alu_w = {1'b0, ~alu_a};
         ALU_SHL:   alu_w = {alu_a, 1'b0};
         ALU_SHR:   alu_w = {alu_a[0], 1'b0, alu_a[7:1]};
         ALU_INC:   alu_w = {1'b0, alu_a} + 9'd1;
         ALU_DEC:   alu_w = {1'b0, alu_a} - 9'd1;
         ALU_PASSA: alu_w = {1'b0, alu_a};
         ALU_PASSB: alu_w = {1'b0, acc};
         ALU_NAND:  alu_w = {1'b0, ~(alu_a & acc)};
         ALU_NOR:   alu_w = {1'b0, ~(alu_a | acc)};
         ALU_XNOR:  alu_w = {1'b0, ~(alu_a ^ acc)};
         ALU_EQ:    alu_w = {8'h00, (alu_a == acc)};
         default:   alu_w = 9'h000;
      endcase
      alu_out   = alu_w[7:0];
      alu_carry = alu_w[8];
   end

   // Accumulator model
   always @(posedge clk) begin
      if (rst)          acc <= 8'h00;
      else if (acc_rst) acc <= 8'h00;
      else if (acc_en)  acc <= alu_out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      logic took;
      took = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (took) cmd_valid = 1'b0;
      if (acc_en) saw_acc_en = 1'b1;
   endtask

   task automatic send(input logic [1:0] kind, input logic [3:0] sel, input logic [7:0] imm);
      cmd_kind  = kind;
      cmd_sel   = sel;
      cmd_imm   = imm;
      cmd_valid = 1'b1;
      for (int i = 0; i < 40 && cmd_valid; i++) step();
      check("send_accepted", 32'(!cmd_valid), 32'd1);
      cmd_valid = 1'b0;
   endtask

   // Wait (bounded) for a result, check it, then consume it if res_ready is high
   task automatic wait_result(input string tag, input logic [7:0] d, input logic c,
                              output int at_cyc);
      for (int i = 0; i < 40 && !res_valid; i++) step();
      at_cyc = cyc;
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_data"}, 32'(res_data), 32'(d));
      check({tag, "_carry"}, 32'(res_carry), 32'(c));
      check({tag, "_opnd_off"}, 32'(opnd_en), 32'd0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int t_res;
      int prev;
      logic [7:0] burst_exp [6];

      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_kind   = KIND_EXEC;
      cmd_sel    = ALU_ADD;
      cmd_imm    = 8'h00;
      res_ready  = 1'b1;
      saw_acc_en = 1'b0;

      // Reset state
      step();
      step();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_opnd_en", 32'(opnd_en), 32'd0);
      check("rst_acc_en", 32'(acc_en), 32'd0);
      check("rst_acc_rst", 32'(acc_rst), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // LOAD 05 stepped cycle by cycle from push edge 0
      send(KIND_LOAD, ALU_ADD, 8'h05);
      t0 = cyc;
      check("load_busy", 32'(busy), 32'd1);
      step();
      check("load_fetch_acc_rst", 32'(acc_rst), 32'd1);
      check("load_fetch_opnd_en", 32'(opnd_en), 32'd0);
      step();
      check("load_opnd_en", 32'(opnd_en), 32'd1);
      check("load_opnd_data", 32'(opnd_data), 32'h05);
      check("load_opnd_sel", 32'(alu_sel), 32'(ALU_ADD));
      check("load_opnd_acc_en", 32'(acc_en), 32'd0);
      step();
      check("load_exec_acc_en", 32'(acc_en), 32'd1);
      check("load_exec_res_valid", 32'(res_valid), 32'd0);
      step();
      check("load_latency", 32'(cyc - t0), 32'd4);
      check("load_res_valid", 32'(res_valid), 32'd1);
      check("load_res_data", 32'(res_data), 32'h05);
      check("load_acc_en_off", 32'(acc_en), 32'd0);
      check("load_acc", 32'(acc), 32'h05);
      step();
      check("load_res_taken", 32'(res_valid), 32'd0);
      check("load_idle_busy", 32'(busy), 32'd0);

      // EXEC ADD 03 onto acc=05
      send(KIND_EXEC, ALU_ADD, 8'h03);
      wait_result("add_5_3", 8'h08, 1'b0, t_res);
      check("add_5_3_acc", 32'(acc), 32'h08);

      // Carry out of the top bit
      send(KIND_LOAD, ALU_ADD, 8'hFF);
      wait_result("load_ff", 8'hFF, 1'b0, t_res);
      send(KIND_EXEC, ALU_ADD, 8'h01);
      wait_result("add_ff_1", 8'h00, 1'b1, t_res);
      check("add_ff_1_acc", 32'(acc), 32'h00);

      // READ returns acc without loading it
      send(KIND_LOAD, ALU_ADD, 8'h2A);
      wait_result("load_2a", 8'h2A, 1'b0, t_res);
      saw_acc_en = 1'b0;
      send(KIND_READ, ALU_SUB, 8'h77);
      wait_result("read_2a", 8'h2A, 1'b0, t_res);
      check("read_2a_no_acc_en", 32'(saw_acc_en), 32'd0);
      check("read_2a_acc", 32'(acc), 32'h2A);

      // CLEAR then READ
      saw_acc_en = 1'b0;
      send(KIND_CLEAR, ALU_ADD, 8'h99);
      wait_result("clear", 8'h00, 1'b0, t_res);
      check("clear_no_acc_en", 32'(saw_acc_en), 32'd0);
      check("clear_acc", 32'(acc), 32'h00);
      send(KIND_READ, ALU_ADD, 8'h55);
      wait_result("read_0", 8'h00, 1'b0, t_res);
      check("read_0_no_acc_en", 32'(saw_acc_en), 32'd0);

      // Fill: 4 queued + 1 in flight while results are blocked
      res_ready = 1'b0;
      send(KIND_LOAD, ALU_ADD, 8'h10);
      send(KIND_EXEC, ALU_ADD, 8'h01);
      send(KIND_EXEC, ALU_ADD, 8'h02);
      send(KIND_EXEC, ALU_ADD, 8'h03);
      send(KIND_EXEC, ALU_ADD, 8'h04);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      // 6th command waits on the full FIFO
      cmd_kind  = KIND_EXEC;
      cmd_sel   = ALU_ADD;
      cmd_imm   = 8'h05;
      cmd_valid = 1'b1;
      step();
      step();
      step();
      check("full_still_refused", 32'(cmd_ready), 32'd0);
      check("full_res_held", 32'(res_valid), 32'd1);
      check("full_res_stable", 32'(res_data), 32'h10);
      check("full_busy", 32'(busy), 32'd1);

      burst_exp[0] = 8'h10;
      burst_exp[1] = 8'h11;
      burst_exp[2] = 8'h13;
      burst_exp[3] = 8'h16;
      burst_exp[4] = 8'h1A;
      burst_exp[5] = 8'h1F;
      res_ready = 1'b1;
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         wait_result($sformatf("burst%0d", k), burst_exp[k], 1'b0, t_res);
         if (k > 0) check($sformatf("burst%0d_interval", k), 32'(t_res - prev), 32'd4);
         prev = t_res;
      end
      check("burst_6th_accepted", 32'(cmd_valid), 32'd0);
      step();
      check("burst_done_busy", 32'(busy), 32'd0);

      // Reset during EXEC of a queued burst
      send(KIND_LOAD, ALU_ADD, 8'h07);
      send(KIND_EXEC, ALU_ADD, 8'h01);
      send(KIND_EXEC, ALU_ADD, 8'h01);
      step();
      check("abort_in_exec", 32'(acc_en), 32'd1);
      rst = 1'b1;
      step();
      check("abort_res_valid", 32'(res_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_acc_en", 32'(acc_en), 32'd0);
      check("abort_acc_rst", 32'(acc_rst), 32'd0);
      check("abort_opnd_en", 32'(opnd_en), 32'd0);
      rst = 1'b0;
      saw_acc_en = 1'b0;
      step();
      check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < 6; i++) step();
      check("abort_fifo_dropped", 32'(busy), 32'd0);
      check("abort_no_result", 32'(res_valid), 32'd0);
      check("abort_no_acc_en", 32'(saw_acc_en), 32'd0);

      // Single READ into an idle block: result exactly 4 cycles after push
      send(KIND_LOAD, ALU_ADD, 8'h3C);
      wait_result("load_3c", 8'h3C, 1'b0, t_res);
      step();
      send(KIND_READ, ALU_ADD, 8'h00);
      t0 = cyc;
      wait_result("read_3c", 8'h3C, 1'b0, t_res);
      check("read_latency", 32'(t_res - t0), 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
